// File: rtl/mips_mem_arbiter.sv
// Memory-port arbiter for SimpleMIPS_CPU: shares one single-ported memory
// between instruction fetch and load/store. Data normally wins a contended
// grant; fetch is forced through after STARVE_LIMIT consecutive contended
// data grants. A stalled memory is aborted after TIMEOUT cycles in WAIT and
// flagged on a sticky error bit.
module mips_mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 2,
  parameter int TIMEOUT      = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          owner,
  output logic          err
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_nxt;
  logic [TW-1:0] r_to_cnt;
  logic          w_grant;
  logic          w_pick_data;
  logic          w_timeout;
  logic          r_owner;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_err;

  // Memory gave up: last allowed WAIT cycle passed without a ready strobe.
  assign w_timeout = (r_state == ST_WAIT) && !mem_ready && (r_to_cnt == TO_LAST);

  // Next-state, grant decision and starvation bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_pick_data  = 1'b0;
    w_starve_nxt = r_starve_cnt;
    case (r_state)
      ST_IDLE: begin
        if (if_req && d_req) begin
          w_grant = 1'b1;
          if (r_starve_cnt < STARVE_MAX) begin
            w_pick_data  = 1'b1;
            w_starve_nxt = r_starve_cnt + 1'b1;
          end else begin
            w_starve_nxt = '0;
          end
        end else if (d_req) begin
          // Uncontended data grant does not count toward fetch starvation.
          w_grant     = 1'b1;
          w_pick_data = 1'b1;
        end else if (if_req) begin
          w_grant      = 1'b1;
          w_starve_nxt = '0;
        end
        if (w_grant) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ready || w_timeout) w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and starvation counter registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Latch the winner's request into the memory-side registers on grant.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_owner     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant) begin
      r_owner     <= w_pick_data;
      r_mem_we    <= w_pick_data & d_we;
      r_mem_addr  <= w_pick_data ? d_addr : if_addr;
      r_mem_wdata <= w_pick_data ? d_wdata : '0;
    end
  end

  // WAIT-cycle timeout counter and sticky error flag.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_to_cnt <= '0;
      end else if ((r_state == ST_WAIT) && !mem_ready && (r_to_cnt != TO_LAST)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  // Capture read data on completion; stores never touch d_rdata.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if ((r_state == ST_WAIT) && mem_ready) begin
      if (!r_owner)       r_if_rdata <= mem_rdata;
      else if (!r_mem_we) r_d_rdata  <= mem_rdata;
    end
  end

  assign mem_req   = (r_state == ST_WAIT);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state == ST_WAIT) || (r_state == ST_RESP);
  assign if_ack    = (r_state == ST_RESP) && !r_owner;
  assign d_ack     = (r_state == ST_RESP) && r_owner;
  assign owner     = r_owner;
  assign err       = r_err;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_mips_mem_arbiter;

  localparam int AW           = 16;
  localparam int DW           = 16;
  localparam int STARVE_LIMIT = 2;
  localparam int TIMEOUT      = 8;
  localparam int RAND_CYCLES  = 3000;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;
  logic          owner;
  logic          err;

  int checks = 0;
  int errors = 0;

  mips_mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mem_req"},   mem_req,   0);
    check({pfx, "_mem_we"},    mem_we,    0);
    check({pfx, "_mem_addr"},  mem_addr,  0);
    check({pfx, "_mem_wdata"}, mem_wdata, 0);
    check({pfx, "_if_ack"},    if_ack,    0);
    check({pfx, "_d_ack"},     d_ack,     0);
    check({pfx, "_if_rdata"},  if_rdata,  0);
    check({pfx, "_d_rdata"},   d_rdata,   0);
    check({pfx, "_busy"},      busy,      0);
    check({pfx, "_owner"},     owner,     0);
    check({pfx, "_err"},       err,       0);
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit            waiting;   // request raised, not yet granted
    bit            inflight;  // granted, ack not yet seen
    bit            drop;      // requester released req after grant
    logic [AW-1:0] addr;
    bit            we;
    logic [DW-1:0] wdata;
    int            idx;
  } rq_t;

  rq_t           rq_i, rq_d, m_txn;
  logic [AW-1:0] addr_tab [16];
  logic [DW-1:0] exp_mem [16];
  logic [DW-1:0] rsp_mem [logic [AW-1:0]];
  bit            m_active, m_owner, m_timeout, exp_err, in_wait, is_ack;
  int            m_gc, m_w, m_delay, m_streak, m_next, sel;
  logic [DW-1:0] exp_if_rd, exp_d_rd;

  task automatic new_req(inout rq_t r, input bit is_data);
    if (!r.waiting && !r.inflight && $urandom_range(0, 1) == 1) begin
      r.waiting = 1'b1;
      r.drop    = 1'b0;
      r.idx     = int'($urandom_range(0, 15));
      r.addr    = addr_tab[r.idx];
      r.we      = is_data && ($urandom_range(0, 1) == 1);
      r.wdata   = 16'($urandom);
    end else if (r.inflight && !r.drop && $urandom_range(0, 7) == 0) begin
      r.drop = 1'b1;
    end
  endtask

  // Directed-scenario bookkeeping.
  bit t3_order [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  bit t3_own [$];
  int t3_cyc [$];
  int waits;

  initial begin
    // Reset with busy-looking inputs: everything must read zero.
    if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    tick(); tick();
    check_all_zero("reset");
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    resetn = 1'b1;
    tick();

    // 1: fetch only, two-cycle latency.
    if_req = 1'b1; if_addr = 16'h0004;
    tick();
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_addr", mem_addr, 16'h0004);
    check("t1_mem_we", mem_we, 0);
    check("t1_busy", busy, 1);
    check("t1_early_ack", if_ack, 0);
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    tick();
    check("t1_if_ack", if_ack, 1);
    check("t1_if_rdata", if_rdata, 16'h1234);
    check("t1_owner", owner, 0);
    check("t1_resp_mem_req", mem_req, 0);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("t1_ack_one_cycle", if_ack, 0);
    check("t1_idle_busy", busy, 0);

    // 2: store held three WAIT cycles, d_rdata untouched.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF; mem_rdata = 16'h5555;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t2_mem_req", mem_req, 1);
      check("t2_mem_we", mem_we, 1);
      check("t2_mem_addr", mem_addr, 16'h0010);
      check("t2_mem_wdata", mem_wdata, 16'hBEEF);
      check("t2_no_ack", d_ack, 0);
      if (i == 2) mem_ready = 1'b1;
      tick();
    end
    check("t2_d_ack", d_ack, 1);
    check("t2_d_rdata", d_rdata, 0);
    check("t2_owner", owner, 1);
    d_req = 1'b0; mem_ready = 1'b0;
    tick();

    // 2b: ready on the last allowed WAIT cycle is a normal completion.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0012;
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      check("t2b_mem_req", mem_req, 1);
      if (i == TIMEOUT - 1) begin mem_ready = 1'b1; mem_rdata = 16'h9ABC; end
      tick();
    end
    check("t2b_d_ack", d_ack, 1);
    check("t2b_err", err, 0);
    check("t2b_d_rdata", d_rdata, 16'h9ABC);
    d_req = 1'b0; mem_ready = 1'b0;
    tick();

    // 3: continuous contention: D, D, F, D, D, F with acks every 3 cycles.
    if_req = 1'b1; if_addr = 16'h0040; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    mem_ready = 1'b1; mem_rdata = 16'hA5A5;
    for (int n = 1; n <= 40 && t3_own.size() < 6; n++) begin
      tick();
      if (if_ack || d_ack) begin
        t3_own.push_back(d_ack);
        t3_cyc.push_back(n);
        if (t3_own.size() == 6) begin if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; end
      end
    end
    check("t3_ack_count", t3_own.size(), 6);
    for (int k = 0; k < t3_own.size() && k < 6; k++) begin
      check("t3_grant_order", t3_own[k], t3_order[k]);
      check("t3_ack_cycle", t3_cyc[k], 2 + 3 * k);
    end
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    tick();

    // 4: load with a stalled memory times out after TIMEOUT WAIT cycles.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030; mem_rdata = 16'hFFFF;
    tick();
    waits = 0;
    for (int n = 0; n < 20 && !d_ack; n++) begin
      if (mem_req) waits++;
      tick();
    end
    check("t4_wait_cycles", waits, TIMEOUT);
    check("t4_d_ack", d_ack, 1);
    check("t4_err", err, 1);
    check("t4_d_rdata_kept", d_rdata, 16'hA5A5);
    d_req = 1'b0;
    tick();
    check("t4_err_sticky", err, 1);
    if_req = 1'b1; if_addr = 16'h0050;
    tick();
    mem_ready = 1'b1; mem_rdata = 16'h4321;
    tick();
    check("t4_fetch_ack", if_ack, 1);
    check("t4_fetch_rdata", if_rdata, 16'h4321);
    check("t4_err_still", err, 1);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();

    // 5: two contended data grants, then reset in the second WAIT cycle of a
    // third access; the starvation count must be cleared by reset.
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h0BAD;
    for (int n = 0; n < 5; n++) tick();
    check("t5_second_d_ack", d_ack, 1);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    check("t5_wait1_mem_req", mem_req, 1);
    check("t5_wait1_owner", owner, 1);
    tick();
    resetn = 1'b0;
    tick();
    check_all_zero("t5_reset");
    resetn = 1'b1; if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1111;
    tick();
    check("t5_data_wins", owner, 1);
    check("t5_mem_req", mem_req, 1);
    tick();
    check("t5_d_ack", d_ack, 1);
    check("t5_d_rdata", d_rdata, 16'h1111);
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    tick();

    // 6: fetch dropped right after grant still completes, no second access.
    if_req = 1'b1; if_addr = 16'h0060;
    tick();
    check("t6_mem_req", mem_req, 1);
    if_req = 1'b0; if_addr = 16'hFFFF;
    tick();
    check("t6_addr_held", mem_addr, 16'h0060);
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick();
    check("t6_if_ack", if_ack, 1);
    check("t6_if_rdata", if_rdata, 16'h7777);
    mem_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("t6_no_reissue", mem_req, 0);
      check("t6_no_ack", if_ack, 0);
    end

    // Randomized run against the reference model, from a fresh reset.
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr_tab[i] = {4'(i), 12'($urandom)};
      exp_mem[i]  = 16'($urandom);
      rsp_mem[addr_tab[i]] = exp_mem[i];
    end
    rq_i = '{default: 0}; rq_d = '{default: 0}; m_txn = '{default: 0};
    m_active = 1'b0; m_owner = 1'b0; m_timeout = 1'b0; exp_err = 1'b0;
    m_streak = 0; m_next = 0; m_gc = 0; m_w = 0; m_delay = 0;
    exp_if_rd = '0; exp_d_rd = '0;

    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      in_wait = m_active && (cyc > m_gc) && (cyc <= m_gc + m_w);
      is_ack  = m_active && (cyc == m_gc + m_w + 1);
      if (is_ack) begin
        if (m_timeout)      exp_err = 1'b1;
        else if (!m_owner)  exp_if_rd = exp_mem[m_txn.idx];
        else if (!m_txn.we) exp_d_rd  = exp_mem[m_txn.idx];
        else                exp_mem[m_txn.idx] = m_txn.wdata;
      end
      check("r_mem_req", mem_req, in_wait);
      check("r_busy", busy, in_wait || is_ack);
      check("r_if_ack", if_ack, is_ack && !m_owner);
      check("r_d_ack", d_ack, is_ack && m_owner);
      check("r_err", err, exp_err);
      check("r_if_rdata", if_rdata, exp_if_rd);
      check("r_d_rdata", d_rdata, exp_d_rd);
      if (in_wait || is_ack) check("r_owner", owner, m_owner);
      if (in_wait) begin
        check("r_mem_addr", mem_addr, m_txn.addr);
        check("r_mem_we", mem_we, m_owner && m_txn.we);
        if (m_owner && m_txn.we) check("r_mem_wdata", mem_wdata, m_txn.wdata);
      end
      if (is_ack) begin
        m_active = 1'b0;
        m_next   = cyc + 1;
        if (m_owner) rq_d.inflight = 1'b0;
        else         rq_i.inflight = 1'b0;
      end

      new_req(rq_i, 1'b0);
      new_req(rq_d, 1'b1);

      // Arbitration rule: data wins contention until STARVE_LIMIT in a row.
      if (!m_active && cyc >= m_next && (rq_i.waiting || rq_d.waiting)) begin
        if (rq_i.waiting && rq_d.waiting) begin
          if (m_streak < STARVE_LIMIT) begin m_owner = 1'b1; m_streak++; end
          else begin m_owner = 1'b0; m_streak = 0; end
        end else if (rq_d.waiting) begin
          m_owner = 1'b1;
        end else begin
          m_owner = 1'b0; m_streak = 0;
        end
        if (m_owner) begin
          m_txn = rq_d; rq_d.waiting = 1'b0; rq_d.inflight = 1'b1;
        end else begin
          m_txn = rq_i; m_txn.we = 1'b0; rq_i.waiting = 1'b0; rq_i.inflight = 1'b1;
        end
        sel = int'($urandom_range(0, 9));
        if (sel < 7)                        m_delay = int'($urandom_range(0, 3));
        else if (sel == 7 || cyc < RAND_CYCLES / 2) m_delay = TIMEOUT - 1;
        else                                m_delay = TIMEOUT + 1;
        m_timeout = (m_delay >= TIMEOUT);
        m_w       = m_timeout ? TIMEOUT : m_delay + 1;
        m_gc      = cyc;
        m_active  = 1'b1;
      end

      if_req  = rq_i.waiting || (rq_i.inflight && !rq_i.drop);
      if_addr = if_req ? rq_i.addr : 16'($urandom);
      d_req   = rq_d.waiting || (rq_d.inflight && !rq_d.drop);
      d_addr  = d_req ? rq_d.addr : 16'($urandom);
      d_we    = d_req ? rq_d.we : ($urandom_range(0, 1) == 1);
      d_wdata = d_req ? rq_d.wdata : 16'($urandom);

      // Memory responder: ready after m_delay WAIT cycles, noise elsewhere.
      if (in_wait && (cyc - m_gc - 1 == m_delay)) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          rsp_mem[mem_addr] = mem_wdata;
          mem_rdata = 16'($urandom);
        end else begin
          mem_rdata = rsp_mem.exists(mem_addr) ? rsp_mem[mem_addr] : 16'hDEAD;
        end
      end else begin
        mem_ready = in_wait ? 1'b0 : ($urandom_range(0, 1) == 1);
        mem_rdata = 16'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
